// File: rtl/cook_program_sequencer.sv
// cook_program_sequencer: multi-stage microwave cook controller.
// Holds the stage program, drives the minutes/seconds counter load and
// decrement, duty-cycles the magnetron by stage power and reacts to
// start/stop/clear/door events.
// Optional feature: define COOK_SEQ_BEEP_EN to build the completion beeper.
module cook_program_sequencer #(
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned DUTY_WIN   = 10,
  parameter int unsigned BEEP_TICKS = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sec_tick,
  input  logic              start_p,
  input  logic              stop_p,
  input  logic              clear_p,
  input  logic              door_closed,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [11:0]       cfg_time,
  input  logic [3:0]        cfg_power,
  input  logic              cnt_zero,
  output logic              cnt_load,
  output logic [11:0]       cnt_load_val,
  output logic              cnt_dec_en,
  output logic              mag_on,
  output logic [ADDR_W-1:0] stage_idx,
  output logic              busy,
  output logic              done,
  output logic              beep
);

  localparam int unsigned STAGES = 2 ** ADDR_W;
  localparam int unsigned TIME_W = 12;
  localparam int unsigned PWR_W  = 4;
  localparam int unsigned DUTY_W = (DUTY_WIN > 1) ? $clog2(DUTY_WIN) : 1;

  localparam logic [PWR_W-1:0]  PWR_MAX   = PWR_W'(10);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(STAGES - 1);
  localparam logic [DUTY_W-1:0] DUTY_LAST = DUTY_W'(DUTY_WIN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state;
  logic [TIME_W-1:0]   stage_time  [STAGES];
  logic [PWR_W-1:0]    stage_power [STAGES];
  logic [ADDR_W-1:0]   idx;
  logic [DUTY_W-1:0]   duty_cnt;
  logic                done_r;

  logic [ADDR_W-1:0]   idx_next;
  logic                cfg_open;
  logic                in_cook;
  logic                cook_run;
  logic                last_stage;
  logic                done_set;

  assign idx_next   = idx + ADDR_W'(1);
  assign cfg_open   = (state == S_IDLE) || (state == S_DONE);
  assign in_cook    = (state == S_COOK);
  // COOK with no higher-priority event pending this cycle
  assign cook_run   = in_cook && !clear_p && !stop_p && door_closed;
  assign last_stage = (idx == LAST_IDX) || (stage_time[idx_next] == '0);
  assign done_set   = cook_run && cnt_zero && last_stage;

  assign stage_idx    = idx;
  assign busy         = (state == S_LOAD) || (state == S_COOK) || (state == S_PAUSE);
  assign done         = done_r;
  assign cnt_load     = (state == S_LOAD);
  assign cnt_load_val = cnt_load ? stage_time[idx] : '0;
  // A tick that meets the zero/transition cycle is swallowed, not forwarded
  assign cnt_dec_en   = cook_run && !cnt_zero && sec_tick;
  // Magnetron drops in the same cycle the door opens
  assign mag_on       = in_cook && door_closed &&
                        (8'(duty_cnt) < 8'(stage_power[idx]));

  // Stage program storage; writable only while no program is running
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_time[i]  <= '0;
        stage_power[i] <= '0;
      end
    end else if (cfg_we && cfg_open) begin
      stage_time[cfg_addr]  <= cfg_time;
      stage_power[cfg_addr] <= (cfg_power > PWR_MAX) ? PWR_MAX : cfg_power;
    end
  end

  // Sequencer FSM: clear > stop > door open > start > tick/zero
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      duty_cnt <= '0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (clear_p) begin
        state <= S_IDLE;
        idx   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_p && !stop_p && door_closed && (stage_time[0] != '0)) begin
              state <= S_LOAD;
              idx   <= '0;
            end
          end
          S_LOAD: begin
            duty_cnt <= '0;
            state    <= S_COOK;
          end
          S_COOK: begin
            if (stop_p || !door_closed) begin
              state <= S_PAUSE;
            end else if (cnt_zero) begin
              if (last_stage) begin
                state  <= S_DONE;
                done_r <= 1'b1;
              end else begin
                idx   <= idx_next;
                state <= S_LOAD;
              end
            end else if (sec_tick) begin
              duty_cnt <= (duty_cnt == DUTY_LAST) ? '0 : duty_cnt + DUTY_W'(1);
            end
          end
          S_PAUSE: begin
            if (stop_p) begin
              state <= S_IDLE;
              idx   <= '0;
            end else if (start_p && door_closed) begin
              state <= S_COOK;
            end
          end
          S_DONE: begin
            if (stop_p) begin
              state <= S_IDLE;
              idx   <= '0;
            end else if (start_p && door_closed && (stage_time[0] != '0)) begin
              state <= S_LOAD;
              idx   <= '0;
            end
          end
          default: begin
            state <= S_IDLE;
            idx   <= '0;
          end
        endcase
      end
    end
  end

`ifdef COOK_SEQ_BEEP_EN
  localparam int unsigned BEEP_W = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;
  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_TICKS - 1);

  logic              beep_r;
  logic [BEEP_W-1:0] beep_cnt;

  // Completion beeper: rises with done, lasts BEEP_TICKS seconds
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      beep_r   <= 1'b0;
      beep_cnt <= '0;
    end else if (done_set) begin
      beep_r   <= 1'b1;
      beep_cnt <= '0;
    end else if (clear_p || start_p) begin
      beep_r   <= 1'b0;
      beep_cnt <= '0;
    end else if (beep_r && sec_tick) begin
      if (beep_cnt == BEEP_LAST) begin
        beep_r <= 1'b0;
      end else begin
        beep_cnt <= beep_cnt + BEEP_W'(1);
      end
    end
  end

  assign beep = beep_r;
`else
  // Beeper not built; parameter kept so both builds share one interface
  assign beep = 1'b0 && (BEEP_TICKS != 0);
`endif

endmodule

// File: tb/tb_cook_program_sequencer.sv
// tb_cook_program_sequencer: directed scoreboard bench for the cook sequencer.
// Includes a behavioural minutes/seconds counter that supplies cnt_zero.
module tb_cook_program_sequencer;

  localparam int unsigned ADDR_W = 2;
  localparam int EV_LOAD = 0;
  localparam int EV_TICK = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int kind;
    int data;
  } ev_t;

  logic              clock;
  logic              reset;
  logic              sec_tick;
  logic              start_p;
  logic              stop_p;
  logic              clear_p;
  logic              door_closed;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [11:0]       cfg_time;
  logic [3:0]        cfg_power;
  logic              cnt_zero;
  logic              cnt_load;
  logic [11:0]       cnt_load_val;
  logic              cnt_dec_en;
  logic              mag_on;
  logic [ADDR_W-1:0] stage_idx;
  logic              busy;
  logic              done;
  logic              beep;

  int  errors = 0;
  int  checks = 0;
  int  cnt_secs = 0;
  ev_t sb[$];

  cook_program_sequencer #(.ADDR_W(ADDR_W), .DUTY_WIN(10), .BEEP_TICKS(3)) dut (
    .clock(clock), .reset(reset), .sec_tick(sec_tick), .start_p(start_p),
    .stop_p(stop_p), .clear_p(clear_p), .door_closed(door_closed),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_time(cfg_time),
    .cfg_power(cfg_power), .cnt_zero(cnt_zero), .cnt_load(cnt_load),
    .cnt_load_val(cnt_load_val), .cnt_dec_en(cnt_dec_en), .mag_on(mag_on),
    .stage_idx(stage_idx), .busy(busy), .done(done), .beep(beep)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic int bcd2sec(logic [11:0] v);
    return int'(v[11:8]) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  // Counter model: loads BCD time, decrements on enable
  always @(posedge clock) begin
    if (cnt_load) cnt_secs <= bcd2sec(cnt_load_val);
    else if (cnt_dec_en && cnt_secs > 0) cnt_secs <= cnt_secs - 1;
  end
  assign cnt_zero = (cnt_secs == 0);

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic sb_check(int kind, int data, string name);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event data=%0h while none expected", name, data);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.data != data) begin
        errors++;
        $display("FAIL %s: got kind=%0d data=%0h want kind=%0d data=%0h",
                 name, kind, data, e.kind, e.data);
      end
    end
  endtask

  // Monitor: every DUT output event is matched against the scoreboard
  always @(negedge clock) begin
    if (!reset) begin
      if (cnt_load)   sb_check(EV_LOAD, int'(stage_idx) * 4096 + int'(cnt_load_val), "load");
      if (cnt_dec_en) sb_check(EV_TICK, int'(mag_on) * 16 + int'(stage_idx), "tick");
      if (done)       sb_check(EV_DONE, 0, "done");
    end
  end

  task automatic exp_load(int idx, int val);
    sb.push_back('{EV_LOAD, idx * 4096 + val});
  endtask
  task automatic exp_tick(int mag, int idx);
    sb.push_back('{EV_TICK, mag * 16 + idx});
  endtask
  task automatic exp_done();
    sb.push_back('{EV_DONE, 0});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic tick();
    sec_tick = 1'b1;
    step();
    sec_tick = 1'b0;
    repeat (3) step();
  endtask
  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic pulse_start();
    start_p = 1'b1;
    step();
    start_p = 1'b0;
    repeat (2) step();
  endtask
  task automatic pulse_stop();
    stop_p = 1'b1;
    step();
    stop_p = 1'b0;
    step();
  endtask
  task automatic pulse_clear();
    clear_p = 1'b1;
    step();
    clear_p = 1'b0;
    step();
  endtask
  task automatic cfg_write(int addr, logic [11:0] t, logic [3:0] p);
    cfg_we   = 1'b1;
    cfg_addr = ADDR_W'(addr);
    cfg_time = t;
    cfg_power = p;
    step();
    cfg_we = 1'b0;
  endtask
  task automatic drain(string name);
    for (int i = 0; i < 60 && sb.size() != 0; i++) step();
    repeat (3) step();
    chk(name, sb.size(), 0);
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sec_tick = 1'b0; start_p = 1'b0; stop_p = 1'b0; clear_p = 1'b0;
    door_closed = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_time = '0; cfg_power = '0;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_mag", mag_on, 0);
    chk("rst_load", cnt_load, 0);
    chk("rst_load_val", cnt_load_val, 0);
    chk("rst_dec", cnt_dec_en, 0);
    chk("rst_done", done, 0);
    chk("rst_beep", beep, 0);
    chk("rst_idx", stage_idx, 0);
    reset = 1'b0;
    step();

    // 1: single 3 s stage at full power
    cfg_write(0, 12'h003, 4'd10);
    exp_load(0, 'h003);
    for (int k = 0; k < 3; k++) exp_tick(1, 0);
    exp_done();
    pulse_start();
    chk("t1_busy", busy, 1);
    ticks(3);
    drain("t1_drain");
    chk("t1_idle_busy", busy, 0);

    // 2: 20 s at power 5, 5 on / 5 off twice
    cfg_write(0, 12'h020, 4'd5);
    exp_load(0, 'h020);
    for (int k = 0; k < 20; k++) exp_tick(((k % 10) < 5) ? 1 : 0, 0);
    exp_done();
    pulse_start();
    ticks(20);
    drain("t2_drain");

    // 3: two stages, second is standing time
    cfg_write(0, 12'h002, 4'd10);
    cfg_write(1, 12'h002, 4'd0);
    exp_load(0, 'h002);
    exp_tick(1, 0); exp_tick(1, 0);
    exp_load(1, 'h002);
    exp_tick(0, 1); exp_tick(0, 1);
    exp_done();
    pulse_start();
    ticks(4);
    drain("t3_drain");

    // 4: door opened mid-cook pauses, resume without reload
    cfg_write(1, 12'h000, 4'd0);
    cfg_write(0, 12'h005, 4'd10);
    exp_load(0, 'h005);
    for (int k = 0; k < 5; k++) exp_tick(1, 0);
    exp_done();
    pulse_start();
    ticks(2);
    @(negedge clock);
    chk("t4_mag_pre", mag_on, 1);
    step();
    door_closed = 1'b0;
    @(negedge clock);
    chk("t4_mag_door", mag_on, 0);
    step();
    chk("t4_pause_busy", busy, 1);
    ticks(2);
    door_closed = 1'b1;
    step();
    @(negedge clock);
    chk("t4_pause_mag", mag_on, 0);
    step();
    pulse_start();
    ticks(3);
    drain("t4_drain");

    // 5: stop -> pause -> stop -> idle; clear mid-cook keeps stages
    cfg_write(0, 12'h001, 4'd10);
    cfg_write(1, 12'h003, 4'd10);
    exp_load(0, 'h001); exp_tick(1, 0); exp_load(1, 'h003); exp_tick(1, 1);
    pulse_start();
    ticks(2);
    pulse_stop();
    chk("t5_pause_idx", stage_idx, 1);
    chk("t5_pause_busy", busy, 1);
    pulse_stop();
    chk("t5_stop_idx", stage_idx, 0);
    chk("t5_stop_busy", busy, 0);
    drain("t5a_drain");
    exp_load(0, 'h001); exp_tick(1, 0); exp_load(1, 'h003); exp_tick(1, 1);
    pulse_start();
    ticks(2);
    pulse_clear();
    chk("t5_clr_idx", stage_idx, 0);
    chk("t5_clr_busy", busy, 0);
    drain("t5b_drain");
    exp_load(0, 'h001); exp_tick(1, 0); exp_load(1, 'h003);
    for (int k = 0; k < 3; k++) exp_tick(1, 1);
    exp_done();
    pulse_start();
    ticks(4);
    drain("t5c_drain");

    // 6: config write during cook ignored; beeper; start with door open ignored
    exp_load(0, 'h001); exp_tick(1, 0); exp_load(1, 'h003);
    for (int k = 0; k < 3; k++) exp_tick(1, 1);
    exp_done();
    pulse_start();
    cfg_write(1, 12'h009, 4'd0);
    ticks(4);
    drain("t6_drain");
    chk("t6_done_busy", busy, 0);
`ifdef COOK_SEQ_BEEP_EN
    chk("t6_beep_on", beep, 1);
    ticks(2);
    chk("t6_beep_held", beep, 1);
    tick();
    chk("t6_beep_off", beep, 0);
`else
    chk("t6_beep_tied", beep, 0);
    ticks(3);
    chk("t6_beep_tied2", beep, 0);
`endif
    pulse_clear();
    door_closed = 1'b0;
    pulse_start();
    chk("t6_door_busy", busy, 0);
    door_closed = 1'b1;
    drain("t6b_drain");

    // 7: non-BCD time passed to the counter untouched
    cfg_write(0, 12'h0AB, 4'd3);
    exp_load(0, 'h0AB);
    start_p = 1'b1;
    step();
    start_p = 1'b0;
    step();
    pulse_clear();
    drain("t7_drain");

    // 8: reset mid-cook kills magnetron immediately and clears stages
    cfg_write(0, 12'h005, 4'd10);
    exp_load(0, 'h005);
    pulse_start();
    @(negedge clock);
    chk("t8_mag_pre", mag_on, 1);
    #1 reset = 1'b1;
    #1;
    chk("t8_mag_rst", mag_on, 0);
    chk("t8_busy_rst", busy, 0);
    step();
    reset = 1'b0;
    step();
    pulse_start();
    chk("t8_cleared_busy", busy, 0);
    drain("t8_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
